// File: rtl/rr_mux_arbiter.sv
// Four-source round-robin arbiter with bounded bursts; registers the granted
// source's data onto a single shared output.
module rr_mux_arbiter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] din,
    output logic [3:0]         gnt,
    output logic [1:0]         sel,
    output logic               busy,
    output logic [WIDTH-1:0]   dout,
    output logic               dout_valid
);

    localparam logic [3:0] HoldLim = 4'(MAX_HOLD);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       g_q, g_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;

    logic [WIDTH-1:0] src [4];
    logic             beat, expire, release_now;
    logic [1:0]       arb_ptr;
    logic [2:0]       arb_res;
    logic             win_found;
    logic [1:0]       win_idx;

    // Returns {found, index}: first requester in order p+1, p+2, p+3, p.
    function automatic logic [2:0] arbitrate(input logic [3:0] r, input logic [1:0] p);
        logic       found;
        logic [1:0] idx;
        logic [1:0] cand;
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = p + 2'(i);
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            src[k] = din[k*WIDTH +: WIDTH];
        end
    end

    assign beat        = (state_q == StGrant) && req[g_q];
    assign expire      = beat && ((cnt_q + 4'd1) == HoldLim);
    assign release_now = (state_q == StGrant) && (!req[g_q] || expire);
    // On release the outgoing owner becomes the new pointer, so it ranks last.
    assign arb_ptr     = release_now ? g_q : ptr_q;
    assign arb_res     = arbitrate(req, arb_ptr);
    assign win_found   = arb_res[2];
    assign win_idx     = arb_res[1:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            ptr_q        <= 2'd3;
            g_q          <= 2'd0;
            cnt_q        <= 4'd0;
            gnt_q        <= 4'd0;
            sel_q        <= 2'd0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            g_q          <= g_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            sel_q        <= sel_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        g_d          = g_q;
        cnt_d        = cnt_q;
        gnt_d        = gnt_q;
        sel_d        = sel_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d = StGrant;
                    g_d     = win_idx;
                    gnt_d   = 4'b0001 << win_idx;
                    sel_d   = win_idx;
                    cnt_d   = 4'd0;
                end
            end
            StGrant: begin
                if (beat) begin
                    dout_d       = src[g_q];
                    dout_valid_d = 1'b1;
                    cnt_d        = cnt_q + 4'd1;
                end
                if (release_now) begin
                    ptr_d = g_q;
                    cnt_d = 4'd0;
                    if (win_found) begin
                        g_d   = win_idx;
                        gnt_d = 4'b0001 << win_idx;
                        sel_d = win_idx;
                    end else begin
                        state_d = StIdle;
                        gnt_d   = 4'd0;
                        sel_d   = 2'd0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs come straight from registers; no req-to-output path.
    always_comb begin
        gnt        = gnt_q;
        sel        = sel_q;
        busy       = |gnt_q;
        dout       = dout_q;
        dout_valid = dout_valid_q;
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: reset, bursts, round robin, early drop,
// release priority and asynchronous reset mid-burst.
module tb_rr_mux_arbiter;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned MAX_HOLD = 4;

    logic             clk;
    logic             rst_n;
    logic [3:0]       req;
    logic [4*WIDTH-1:0] din;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic             busy;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;

    int n_checks;
    int n_fail;
    int pulses;

    rr_mux_arbiter #(
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .din        (din),
        .gnt        (gnt),
        .sel        (sel),
        .busy       (busy),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        req   = 4'd0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        req      = 4'b1111;
        din      = {8'h13, 8'h12, 8'h11, 8'h10};

        // Reset / idle
        repeat (2) @(negedge clk);
        check_eq("rst_gnt", 32'(gnt), 32'h0);
        check_eq("rst_sel", 32'(sel), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_dout", 32'(dout), 32'h0);
        check_eq("rst_valid", 32'(dout_valid), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("first_gnt", 32'(gnt), 32'h1);
        check_eq("first_sel", 32'(sel), 32'h0);
        check_eq("first_busy", 32'(busy), 32'h1);
        check_eq("first_valid", 32'(dout_valid), 32'h0);

        // Round robin with all requesting
        do_reset();
        req = 4'b1111;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            check_eq("rr_gnt", 32'(gnt), 32'(4'b0001 << (((i - 1) / 4) % 4)));
            check_eq("rr_sel", 32'(sel), 32'(((i - 1) / 4) % 4));
            check_eq("rr_valid", 32'(dout_valid), (i >= 2) ? 32'h1 : 32'h0);
            if (i >= 2) check_eq("rr_dout", 32'(dout), 32'h10 + 32'((i - 2) / 4));
        end

        // Single burst with re-grant of the same source
        do_reset();
        din    = {8'h13, 8'hA5, 8'h11, 8'h10};
        req    = 4'b0100;
        pulses = 0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            check_eq("sb_gnt", 32'(gnt), 32'h4);
            check_eq("sb_sel", 32'(sel), 32'h2);
            if (dout_valid) pulses++;
            if (i >= 2) begin
                check_eq("sb_valid", 32'(dout_valid), 32'h1);
                check_eq("sb_dout", 32'(dout), 32'hA5);
            end
        end
        check_eq("sb_pulses", 32'(pulses), 32'd6);
        req = 4'b0000;
        @(negedge clk);
        check_eq("sb_end_gnt", 32'(gnt), 32'h0);
        check_eq("sb_end_valid", 32'(dout_valid), 32'h0);
        check_eq("sb_end_dout", 32'(dout), 32'hA5);
        check_eq("sb_end_busy", 32'(busy), 32'h0);

        // Early drop by owner 1 with source 3 waiting
        do_reset();
        din    = {8'h13, 8'h12, 8'h11, 8'h10};
        req    = 4'b0010;
        pulses = 0;
        @(negedge clk);
        check_eq("ed_gnt1", 32'(gnt), 32'h2);
        req = 4'b1010;
        repeat (2) begin
            @(negedge clk);
            if (dout_valid) pulses++;
            check_eq("ed_gnt_hold", 32'(gnt), 32'h2);
            check_eq("ed_dout", 32'(dout), 32'h11);
        end
        req = 4'b1000;
        @(negedge clk);
        if (dout_valid) pulses++;
        check_eq("ed_pulses", 32'(pulses), 32'd2);
        check_eq("ed_gnt3", 32'(gnt), 32'h8);
        check_eq("ed_sel3", 32'(sel), 32'h3);
        check_eq("ed_valid_gap", 32'(dout_valid), 32'h0);
        check_eq("ed_dout_held", 32'(dout), 32'h11);
        @(negedge clk);
        check_eq("ed_beat3_valid", 32'(dout_valid), 32'h1);
        check_eq("ed_beat3_dout", 32'(dout), 32'h13);

        // Priority after expiry of owner 3 with 0 and 2 pending
        do_reset();
        req = 4'b1000;
        @(negedge clk);
        check_eq("pr_gnt3", 32'(gnt), 32'h8);
        req = 4'b1101;
        repeat (3) @(negedge clk);
        check_eq("pr_still3", 32'(gnt), 32'h8);
        @(negedge clk);
        check_eq("pr_next_gnt", 32'(gnt), 32'h1);
        check_eq("pr_next_sel", 32'(sel), 32'h0);
        check_eq("pr_last_dout", 32'(dout), 32'h13);
        check_eq("pr_last_valid", 32'(dout_valid), 32'h1);

        // Asynchronous reset during beat 2 of source 1
        do_reset();
        req = 4'b0010;
        repeat (3) @(negedge clk);
        check_eq("mr_valid_pre", 32'(dout_valid), 32'h1);
        check_eq("mr_dout_pre", 32'(dout), 32'h11);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mr_gnt", 32'(gnt), 32'h0);
        check_eq("mr_sel", 32'(sel), 32'h0);
        check_eq("mr_dout", 32'(dout), 32'h0);
        check_eq("mr_valid", 32'(dout_valid), 32'h0);
        check_eq("mr_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b0010;
        @(negedge clk);
        check_eq("mr_regnt", 32'(gnt), 32'h2);
        check_eq("mr_resel", 32'(sel), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
